// File: rtl/acc_sequencer_if.sv
// Byte-stream handshake and datapath control bundle between the sequencer and the
// adder/accumulator datapath.
interface acc_sequencer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
);
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] bus_out;
  logic              bus_oe;
  logic              Ea;
  logic              Eu;
  logic              sub;
  logic              nLa;
  logic              nLb;
  logic              out_we;
  logic              CF;
  logic              ZF;
  logic              cf_q;
  logic              zf_q;
  logic              halted;
  logic              illegal;
  logic [CNT_W-1:0]  retired;

  modport master (
    input  instr, instr_valid, CF, ZF,
    output instr_ready, bus_out, bus_oe, Ea, Eu, sub, nLa, nLb, out_we,
    output cf_q, zf_q, halted, illegal, retired
  );

  modport slave (
    output instr, instr_valid, CF, ZF,
    input  instr_ready, bus_out, bus_oe, Ea, Eu, sub, nLa, nLb, out_we,
    input  cf_q, zf_q, halted, illegal, retired
  );
endinterface

// File: rtl/acc_sequencer.sv
// Opcode/immediate sequencer for the adder/accumulator datapath. All controls are
// registered Moore outputs decoded from the next state and latched opcode.
module acc_sequencer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input logic            clk,
  input logic            rst_n,
  acc_sequencer_if.master io
);

  typedef enum logic [2:0] {StFetch, StOper, StExec1, StExec2, StHalt} state_e;

  localparam logic [3:0] OpNop = 4'h0;
  localparam logic [3:0] OpLda = 4'h1;
  localparam logic [3:0] OpAdd = 4'h2;
  localparam logic [3:0] OpSub = 4'h3;
  localparam logic [3:0] OpOut = 4'h4;
  localparam logic [3:0] OpClr = 4'h5;
  localparam logic [3:0] OpHlt = 4'hF;

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [DATA_W-1:0] operand_q, operand_d;
  logic              cf_q, cf_d, zf_q, zf_d;
  logic              halted_q, halted_d, illegal_q, illegal_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic              ready_q, ready_d;
  logic              bus_oe_q, bus_oe_d;
  logic [DATA_W-1:0] bus_out_q, bus_out_d;
  logic              ea_q, ea_d, eu_q, eu_d, sub_q, sub_d;
  logic              nla_q, nla_d, nlb_q, nlb_d, out_we_q, out_we_d;

  logic              xfer;
  logic [3:0]        opcode;

  assign xfer   = io.instr_valid && ready_q;
  assign opcode = io.instr[DATA_W-1 -: 4];

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    operand_d = operand_q;
    cf_d      = cf_q;
    zf_d      = zf_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    retired_d = retired_q;

    case (state_q)
      StFetch: begin
        if (xfer) begin
          case (opcode)
            OpLda, OpAdd, OpSub: begin
              op_d    = opcode;
              state_d = StOper;
            end
            OpOut, OpClr: begin
              op_d      = opcode;
              operand_d = '0;
              state_d   = StExec1;
            end
            OpHlt: begin
              halted_d  = 1'b1;
              retired_d = retired_q + CNT_W'(1);
              state_d   = StHalt;
            end
            OpNop: retired_d = retired_q + CNT_W'(1);
            default: begin
              illegal_d = 1'b1;
              retired_d = retired_q + CNT_W'(1);
            end
          endcase
        end
      end
      StOper: begin
        if (xfer) begin
          operand_d = io.instr;
          state_d   = StExec1;
        end
      end
      StExec1: begin
        if (op_q == OpAdd || op_q == OpSub) begin
          state_d = StExec2;
        end else begin
          retired_d = retired_q + CNT_W'(1);
          state_d   = StFetch;
        end
      end
      StExec2: begin
        // ALU result is on the bus now, so its flags describe this operation
        cf_d      = io.CF;
        zf_d      = io.ZF;
        retired_d = retired_q + CNT_W'(1);
        state_d   = StFetch;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  always_comb begin
    ready_d   = (state_d == StFetch) || (state_d == StOper);
    bus_oe_d  = 1'b0;
    bus_out_d = '0;
    ea_d      = 1'b0;
    eu_d      = 1'b0;
    sub_d     = 1'b0;
    nla_d     = 1'b1;
    nlb_d     = 1'b1;
    out_we_d  = 1'b0;

    if (state_d == StExec1) begin
      case (op_d)
        OpLda: begin
          bus_oe_d  = 1'b1;
          bus_out_d = operand_d;
          nla_d     = 1'b0;
        end
        OpAdd, OpSub: begin
          bus_oe_d  = 1'b1;
          bus_out_d = operand_d;
          nlb_d     = 1'b0;
        end
        OpOut: begin
          ea_d     = 1'b1;
          out_we_d = 1'b1;
        end
        OpClr: begin
          bus_oe_d = 1'b1;
          nla_d    = 1'b0;
        end
        default: ;
      endcase
    end else if (state_d == StExec2) begin
      eu_d  = 1'b1;
      sub_d = (op_d == OpSub);
      nla_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      op_q      <= OpNop;
      operand_q <= '0;
      cf_q      <= 1'b0;
      zf_q      <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
      ready_q   <= 1'b1;
      bus_oe_q  <= 1'b0;
      bus_out_q <= '0;
      ea_q      <= 1'b0;
      eu_q      <= 1'b0;
      sub_q     <= 1'b0;
      nla_q     <= 1'b1;
      nlb_q     <= 1'b1;
      out_we_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      operand_q <= operand_d;
      cf_q      <= cf_d;
      zf_q      <= zf_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
      ready_q   <= ready_d;
      bus_oe_q  <= bus_oe_d;
      bus_out_q <= bus_out_d;
      ea_q      <= ea_d;
      eu_q      <= eu_d;
      sub_q     <= sub_d;
      nla_q     <= nla_d;
      nlb_q     <= nlb_d;
      out_we_q  <= out_we_d;
    end
  end

  assign io.instr_ready = ready_q;
  assign io.bus_oe      = bus_oe_q;
  assign io.bus_out     = bus_out_q;
  assign io.Ea          = ea_q;
  assign io.Eu          = eu_q;
  assign io.sub         = sub_q;
  assign io.nLa         = nla_q;
  assign io.nLb         = nlb_q;
  assign io.out_we      = out_we_q;
  assign io.cf_q        = cf_q;
  assign io.zf_q        = zf_q;
  assign io.halted      = halted_q;
  assign io.illegal     = illegal_q;
  assign io.retired     = retired_q;

endmodule

// File: tb/tb_acc_sequencer.sv
// Self-checking bench for acc_sequencer: directed vector table, corner sequences, and a
// randomized program checked against an instruction-level event model.
module tb_acc_sequencer;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 8;

  // Control vector: {instr_ready, bus_oe, Ea, Eu, sub, nLa, nLb, out_we}
  localparam logic [7:0] CtlIdle  = 8'b1000_0110;
  localparam logic [7:0] CtlHalt  = 8'b0000_0110;
  localparam logic [7:0] CtlLda   = 8'b0100_0010;
  localparam logic [7:0] CtlAddE1 = 8'b0100_0100;
  localparam logic [7:0] CtlAddE2 = 8'b0001_0010;
  localparam logic [7:0] CtlSubE2 = 8'b0001_1010;
  localparam logic [7:0] CtlOut   = 8'b0010_0111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  acc_sequencer_if #(.DATA_W(DW), .CNT_W(CW)) bus_if ();

  acc_sequencer #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus_if.master)
  );

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  logic [15:0] obs_q[$];
  logic [15:0] exp_q[$];
  int exp_ret = 0;

  typedef struct {
    logic [7:0] op;
    logic [7:0] imm;
    bit         two_byte;
    bit         cf;
    bit         zf;
    logic [7:0] e1_ctl;
    logic [7:0] e1_bus;
    bit         has_e2;
    logic [7:0] e2_ctl;
    bit         exp_cf;
    bit         exp_zf;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [7:0] ctl_now();
    return {bus_if.instr_ready, bus_if.bus_oe, bus_if.Ea, bus_if.Eu, bus_if.sub,
            bus_if.nLa, bus_if.nLb, bus_if.out_we};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    logic [7:0] c;
    @(posedge clk);
    #1;
    if (mon_en) begin
      c = ctl_now();
      check("bus_onehot", 32'($countones({bus_if.bus_oe, bus_if.Ea, bus_if.Eu}) <= 1), 1);
      check("bus_out_zero", 32'(bus_if.bus_oe || (bus_if.bus_out == 0)), 1);
      if (c != CtlIdle) obs_q.push_back({c, bus_if.bus_out});
    end
  endtask

  task automatic idle(input int n);
    bus_if.instr_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Offer a byte and hold it until the sequencer takes it.
  task automatic send_byte(input logic [7:0] b);
    bit done;
    done = 1'b0;
    bus_if.instr = b;
    bus_if.instr_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      if (bus_if.instr_ready) done = 1'b1;
      tick();
    end
    if (!done) check("send_timeout", 0, 1);
    bus_if.instr_valid = 1'b0;
    bus_if.instr = 8'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus_if.instr = 8'h00;
    bus_if.instr_valid = 1'b1;
    tick();
    tick();
    bus_if.instr_valid = 1'b0;
    rst_n = 1'b1;
    exp_ret = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ctl"}, ctl_now(), CtlIdle);
    check({tag, "_bus_out"}, bus_if.bus_out, 0);
    check({tag, "_flags"}, {bus_if.cf_q, bus_if.zf_q}, 0);
    check({tag, "_halted"}, bus_if.halted, 0);
    check({tag, "_illegal"}, bus_if.illegal, 0);
    check({tag, "_retired"}, bus_if.retired, 0);
  endtask

  task automatic run_random(input int n_instr);
    int kind;
    int n_ret;
    bit exp_ill, ecf, ezf;
    logic [3:0] op;
    logic [7:0] imm;
    int n;
    n_ret = 0;
    exp_ill = 1'b0;
    ecf = 1'b0;
    ezf = 1'b0;
    obs_q.delete();
    exp_q.delete();
    mon_en = 1'b1;
    for (int k = 0; k < n_instr; k++) begin
      kind = $urandom_range(0, 7);
      imm = 8'($urandom);
      case (kind)
        0: op = 4'h0;
        1: op = 4'h1;
        2, 7: op = 4'h2;
        3: op = 4'h3;
        4: op = 4'h4;
        5: op = 4'h5;
        default: op = 4'($urandom_range(6, 14));
      endcase
      idle($urandom_range(0, 2));
      send_byte({op, 4'($urandom)});
      if (op == 4'h1 || op == 4'h2 || op == 4'h3) begin
        if (op != 4'h1) begin
          ecf = 1'($urandom);
          ezf = 1'($urandom);
          bus_if.CF = ecf;
          bus_if.ZF = ezf;
        end
        idle($urandom_range(0, 2));
        send_byte(imm);
      end
      case (op)
        4'h1: exp_q.push_back({CtlLda, imm});
        4'h2: begin
          exp_q.push_back({CtlAddE1, imm});
          exp_q.push_back({CtlAddE2, 8'h00});
        end
        4'h3: begin
          exp_q.push_back({CtlAddE1, imm});
          exp_q.push_back({CtlSubE2, 8'h00});
        end
        4'h4: exp_q.push_back({CtlOut, 8'h00});
        4'h5: exp_q.push_back({CtlLda, 8'h00});
        4'h0: ;
        default: exp_ill = 1'b1;
      endcase
      n_ret++;
    end
    idle(6);
    mon_en = 1'b0;
    check("rand_event_count", obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("rand_event%0d", i), obs_q[i], exp_q[i]);
    check("rand_retired", bus_if.retired, 32'(n_ret & 255));
    check("rand_flags", {bus_if.cf_q, bus_if.zf_q}, {ecf, ezf});
    check("rand_illegal", bus_if.illegal, exp_ill);
    check("rand_halted", bus_if.halted, 0);
  endtask

  initial begin
    bus_if.instr = 8'h00;
    bus_if.instr_valid = 1'b0;
    bus_if.CF = 1'b0;
    bus_if.ZF = 1'b0;

    vecs[0] = '{8'h10, 8'h05, 1, 0, 0, CtlLda,   8'h05, 0, CtlIdle,  0, 0};
    vecs[1] = '{8'h20, 8'h03, 1, 0, 0, CtlAddE1, 8'h03, 1, CtlAddE2, 0, 0};
    vecs[2] = '{8'h30, 8'h05, 1, 1, 1, CtlAddE1, 8'h05, 1, CtlSubE2, 1, 1};
    vecs[3] = '{8'h40, 8'h00, 0, 0, 0, CtlOut,   8'h00, 0, CtlIdle,  1, 1};
    vecs[4] = '{8'h5A, 8'h00, 0, 0, 0, CtlLda,   8'h00, 0, CtlIdle,  1, 1};
    vecs[5] = '{8'h2F, 8'hFF, 1, 1, 0, CtlAddE1, 8'hFF, 1, CtlAddE2, 1, 0};
    vecs[6] = '{8'h07, 8'h00, 0, 1, 1, CtlIdle,  8'h00, 0, CtlIdle,  1, 0};
    vecs[7] = '{8'h1C, 8'hA5, 1, 0, 1, CtlLda,   8'hA5, 0, CtlIdle,  1, 0};
    vecs[8] = '{8'h3E, 8'h01, 1, 0, 1, CtlAddE1, 8'h01, 1, CtlSubE2, 0, 1};

    do_reset();
    check_reset_vals("reset");

    for (int i = 0; i < 9; i++) begin
      bus_if.CF = vecs[i].cf;
      bus_if.ZF = vecs[i].zf;
      send_byte(vecs[i].op);
      if (vecs[i].two_byte) begin
        check($sformatf("v%0d_oper", i), ctl_now(), CtlIdle);
        send_byte(vecs[i].imm);
      end
      check($sformatf("v%0d_e1_ctl", i), ctl_now(), vecs[i].e1_ctl);
      check($sformatf("v%0d_e1_bus", i), bus_if.bus_out, vecs[i].e1_bus);
      exp_ret++;
      if (vecs[i].has_e2) begin
        tick();
        check($sformatf("v%0d_e2_ctl", i), ctl_now(), vecs[i].e2_ctl);
        check($sformatf("v%0d_e2_bus", i), bus_if.bus_out, 0);
      end
      tick();
      check($sformatf("v%0d_done_ctl", i), ctl_now(), CtlIdle);
      check($sformatf("v%0d_flags", i), {bus_if.cf_q, bus_if.zf_q},
            {vecs[i].exp_cf, vecs[i].exp_zf});
      check($sformatf("v%0d_retired", i), bus_if.retired, 32'(exp_ret & 255));
    end
    check("no_illegal_yet", bus_if.illegal, 0);

    // Illegal opcode followed by a gap, then ADD with gaps before its operand
    bus_if.CF = 1'b0;
    bus_if.ZF = 1'b0;
    send_byte(8'h70);
    exp_ret++;
    check("ill_flag", bus_if.illegal, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("ill_gap%0d", k), ctl_now(), CtlIdle);
    end
    check("ill_retired", bus_if.retired, 32'(exp_ret & 255));
    send_byte(8'h25);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("oper_gap%0d", k), ctl_now(), CtlIdle);
    end
    send_byte(8'h11);
    check("gap_e1_ctl", ctl_now(), CtlAddE1);
    check("gap_e1_bus", bus_if.bus_out, 8'h11);
    tick();
    check("gap_e2_ctl", ctl_now(), CtlAddE2);
    tick();
    exp_ret++;
    check("gap_retired", bus_if.retired, 32'(exp_ret & 255));
    check("gap_flags", {bus_if.cf_q, bus_if.zf_q}, 0);

    // Reset during EXEC1 of an arithmetic op
    bus_if.CF = 1'b1;
    send_byte(8'h20);
    send_byte(8'h01);
    tick();
    tick();
    check("pre_rst_cf", bus_if.cf_q, 1);
    send_byte(8'h30);
    send_byte(8'h02);
    check("pre_rst_e1", ctl_now(), CtlAddE1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ctl", ctl_now(), CtlIdle);
    check("rst_mid_bus", bus_if.bus_out, 0);
    check("rst_mid_cf", bus_if.cf_q, 0);
    check("rst_mid_retired", bus_if.retired, 0);
    tick();
    rst_n = 1'b1;
    bus_if.CF = 1'b0;
    exp_ret = 0;

    // HLT is absorbing until reset
    send_byte(8'hF3);
    check("hlt_halted", bus_if.halted, 1);
    check("hlt_ctl", ctl_now(), CtlHalt);
    check("hlt_retired", bus_if.retired, 1);
    bus_if.instr = 8'h10;
    bus_if.instr_valid = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    check("hlt_hold_ctl", ctl_now(), CtlHalt);
    check("hlt_hold_retired", bus_if.retired, 1);
    do_reset();
    check_reset_vals("post_hlt");

    // Retired counter wrap with back-to-back NOPs
    bus_if.instr = 8'h00;
    bus_if.instr_valid = 1'b1;
    for (int k = 0; k < 255; k++) tick();
    check("wrap_255", bus_if.retired, 255);
    tick();
    check("wrap_0", bus_if.retired, 0);
    bus_if.instr_valid = 1'b0;

    do_reset();
    run_random(60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/acc_sequencer.md
# acc_sequencer

Control sequencer for the adder/accumulator datapath. It accepts a byte stream of opcodes and immediate operands over a valid/ready handshake. It drives immediates onto the shared 8-bit bus and issues the one-hot bus enables (operand, accumulator `Ea`, ALU `Eu`) and the active-low load strobes (`nLa`, `nLb`) that the accumulator register and ALU consume. It latches the ALU carry/zero flags after each arithmetic operation and counts retired instructions.

## Interface
- `DATA_W`, default 8: width of the instruction/operand stream and the bus. Must be at least 4; the opcode is `instr[DATA_W-1:DATA_W-4]`.
- `CNT_W`, default 8: width of the retired-instruction counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr`  in  DATA_W  opcode byte or immediate operand byte.
- `instr_valid`  in  1  `instr` holds a valid byte.
- `instr_ready`  out  1  sequencer accepts a byte this cycle.
- `bus_out`  out  DATA_W  immediate value driven to the bus.
- `bus_oe`  out  1  sequencer drives `bus_out` onto the bus.
- `Ea`  out  1  accumulator drives the bus.
- `Eu`  out  1  ALU result drives the bus.
- `sub`  out  1  ALU subtract select.
- `nLa`  out  1  active-low load of the accumulator from the bus.
- `nLb`  out  1  active-low load of the ALU B register from the bus.
- `out_we`  out  1  output-port write strobe (bus to output latch).
- `CF`, `ZF`  in  1 each  live ALU flags.
- `cf_q`, `zf_q`  out  1 each  latched flags.
- `halted`  out  1  HLT executed.
- `illegal`  out  1  sticky flag: an undefined opcode was seen.
- `retired`  out  CNT_W  count of completed instructions.

## Operation
- States: FETCH, OPER, EXEC1, EXEC2, HALT. Reset state is FETCH.
- All control outputs (`bus_oe`, `Ea`, `Eu`, `sub`, `nLa`, `nLb`, `out_we`, `instr_ready`) decode from the state register and the latched opcode only. They are Moore outputs and never depend combinationally on `instr_valid`.
- A byte is transferred on a rising edge where `instr_valid && instr_ready`. `instr_ready` = 1 only in FETCH and OPER.
- Opcodes:
  - 0x0 NOP: 1 byte, no controls, retires directly from FETCH.
  - 0x1 LDA imm: 2 bytes. EXEC1: `bus_oe`=1, `nLa`=0.
  - 0x2 ADD imm: 2 bytes. EXEC1: `bus_oe`=1, `nLb`=0. EXEC2: `Eu`=1, `sub`=0, `nLa`=0.
  - 0x3 SUB imm: same as ADD, but `sub`=1 in EXEC2.
  - 0x4 OUT: 1 byte. EXEC1: `Ea`=1, `out_we`=1.
  - 0x5 CLR: 1 byte. EXEC1: `bus_oe`=1, `bus_out`=0, `nLa`=0.
  - 0xF HLT: go to HALT and set `halted`.
  - Any other opcode: executes as NOP and sets `illegal`. `illegal` clears only on reset.
- State transitions:
  - FETCH to OPER for two-byte opcodes.
  - FETCH to EXEC1 for OUT and CLR.
  - OPER to EXEC1 on operand transfer; the operand is held in an internal register.
  - EXEC1 to EXEC2 for ADD/SUB; otherwise EXEC1 to FETCH.
  - EXEC2 to FETCH.
- Flags: `cf_q`/`zf_q` sample `CF`/`ZF` at the end of EXEC2 only. They are unchanged by all other instructions.
- `retired` increments by 1 on the edge that leaves the last execution state (or FETCH for NOP/illegal, or entry into HALT). It wraps from 2^CNT_W-1 to 0.
- Bus invariant: at most one of `bus_oe`, `Ea`, `Eu` is high in any cycle. `bus_out` is 0 whenever `bus_oe`=0.
- HALT is absorbing: `instr_ready`=0 and all controls inactive until `rst_n` is asserted.

## Timing
- Reset values:
  - State FETCH, so `instr_ready`=1.
  - `bus_oe`=`Ea`=`Eu`=`sub`=`out_we`=0 and `nLa`=`nLb`=1.
  - `bus_out`=0, `cf_q`=`zf_q`=0, `halted`=`illegal`=0, `retired`=0.
  - Bytes presented while `rst_n`=0 are not transferred.
- Reset asserted mid-instruction aborts it immediately and asynchronously: controls go inactive, the operand is discarded, and `retired` does not increment.
- Latency from the last byte's transfer edge to the first control cycle: 1 cycle.
- Busy cycles between opcode accept and the next possible opcode accept:
  - NOP: 0.
  - OUT/CLR: 1.
  - LDA: operand wait + 1.
  - ADD/SUB: operand wait + 2.
- `instr_valid` held high with `instr_ready`=0 transfers nothing. The byte must be held until accepted.
- Every strobe is exactly one cycle wide per instruction.

## Test plan
- Reset, then LDA 0x05: EXEC1 cycle shows `bus_out`=0x05, `bus_oe`=1, `nLa`=0. `retired`=1. No other strobes asserted.
- ADD 0x03 with `CF`=0, `ZF`=0:
  - EXEC1: `nLb`=0, `bus_out`=0x03.
  - EXEC2: `Eu`=1, `sub`=0, `nLa`=0.
  - After EXEC2: `cf_q`=0, `zf_q`=0.
- SUB 0x05 with `CF`=1, `ZF`=1 presented in EXEC2: `sub`=1 in EXEC2 only. `cf_q`=1 and `zf_q`=1 after. A following OUT leaves the flags unchanged and pulses `Ea`=`out_we`=1 for one cycle.
- Opcode byte 0x70 with `instr_valid` dropped for 3 cycles before the operand, and opcode 0x2x with the same gap:
  - 0x70: `illegal`=1, nothing waits in OPER.
  - 0x2x: FETCH/OPER holds `instr_ready`=1 with no strobes until the operand arrives.
- HLT, then keep offering bytes: `halted`=1, `instr_ready`=0 indefinitely. A `rst_n` pulse returns all outputs to their reset values.
- Run 256 NOPs back-to-back with `CNT_W`=8: `retired` wraps to 0. Assert `rst_n`=0 during EXEC1 of ADD: controls are inactive in the same cycle and `cf_q`/`retired` are 0.
